// File: rtl/datapath_pkg.sv
// Shared datapath widths and immediate-extension mode encoding.
package datapath_pkg;

    localparam int IMM8_W = 8;
    localparam int DATA_W = 16;

    typedef enum logic [0:0] {
        EXT_SIGN = 1'b0,
        EXT_ZERO = 1'b1
    } ext_mode_e;

endpackage

// File: rtl/sign_extend_8bit_if.sv
// Immediate-extension request/result bundle between the datapath and the extender.
interface sign_extend_8bit_if #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
);
    logic             in_valid;
    logic [IN_W-1:0]  A;
    logic             zext;
    logic [OUT_W-1:0] B;
    logic             out_valid;

    modport master (
        output in_valid,
        output A,
        output zext,
        input  B,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  A,
        input  zext,
        output B,
        output out_valid
    );
endinterface

// File: rtl/sign_extend_8bit_sext_core.sv
// Combinational immediate widener; shared with other extenders such as branch offsets.
module sext_core
    import datapath_pkg::*;
#(
    parameter int IN_W  = IMM8_W,
    parameter int OUT_W = DATA_W
) (
    input  logic [IN_W-1:0]  A,
    input  logic             zext,
    output logic [OUT_W-1:0] E
);

    ext_mode_e mode;
    logic      fill;

    assign mode = ext_mode_e'(zext);
    assign fill = (mode == EXT_SIGN) ? A[IN_W-1] : 1'b0;
    assign E    = {{(OUT_W-IN_W){fill}}, A};

endmodule

// File: rtl/sign_extend_8bit.sv
// Registered immediate extender: one-cycle latency, result held while no valid input arrives.
module sign_extend_8bit
    import datapath_pkg::*;
#(
    parameter int IN_W  = IMM8_W,
    parameter int OUT_W = DATA_W
) (
    input logic             clk,
    input logic             rst,
    sign_extend_8bit_if.slave bus
);

    if (OUT_W <= IN_W) begin : g_bad_width
        $error("sign_extend_8bit: OUT_W must exceed IN_W");
    end

    logic [OUT_W-1:0] e;
    logic [OUT_W-1:0] b_q;
    logic             valid_q;

    sext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .A    (bus.A),
        .zext (bus.zext),
        .E    (e)
    );

    // B only loads on a valid input so downstream logic sees a stable value otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                b_q <= e;
            end
        end
    end

    assign bus.B         = b_q;
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_sign_extend_8bit.sv
// Self-checking bench for sign_extend_8bit: directed plan followed by random traffic.
module tb_sign_extend_8bit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    logic [15:0] exp_b = 16'h0000;
    logic        exp_v = 1'b0;

    sign_extend_8bit_if #(.IN_W(8), .OUT_W(16)) bus ();

    sign_extend_8bit #(.IN_W(8), .OUT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_ext(input int a, input bit z);
        int v;
        v = (!z && a >= 128) ? a - 256 : a;
        return 16'(v);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    // Apply one cycle of stimulus, advance the reference model, then compare.
    task automatic step(input string tag, input bit r, input bit iv, input logic [7:0] a, input bit z);
        rst          = r;
        bus.in_valid = iv;
        bus.A        = a;
        bus.zext     = z;
        @(posedge clk);
        #1;
        if (r) begin
            exp_b = 16'h0000;
            exp_v = 1'b0;
        end else begin
            exp_v = iv;
            if (iv) exp_b = ref_ext(int'(a), z);
        end
        chk({tag, ".B"}, 32'(bus.B), 32'(exp_b));
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'(exp_v));
    endtask

    initial begin
        logic [8:0] wide;
        logic [7:0] ra;
        bus.in_valid = 1'b1;
        bus.A        = 8'hFF;
        bus.zext     = 1'b0;

        step("rst0", 1, 1, 8'hFF, 0);
        step("rst1", 1, 1, 8'hFF, 0);

        step("s70", 0, 1, 8'h70, 0);
        chk("s70_lit", 32'(bus.B), 32'h0070);
        step("s8f", 0, 1, 8'h8F, 0);
        chk("s8f_lit", 32'(bus.B), 32'hFF8F);
        step("s2a", 0, 1, 8'h2A, 0);
        step("sff", 0, 1, 8'hFF, 0);
        chk("sff_lit", 32'(bus.B), 32'hFFFF);
        step("s0a", 0, 1, 8'h0A, 0);

        step("b7f", 0, 1, 8'h7F, 0);
        chk("b7f_lit", 32'(bus.B), 32'h007F);
        step("b80", 0, 1, 8'h80, 0);
        chk("b80_lit", 32'(bus.B), 32'hFF80);
        step("b00", 0, 1, 8'h00, 0);

        step("z8f", 0, 1, 8'h8F, 1);
        chk("z8f_lit", 32'(bus.B), 32'h008F);
        step("zff", 0, 1, 8'hFF, 1);
        chk("zff_lit", 32'(bus.B), 32'h00FF);

        step("hcap", 0, 1, 8'h8F, 0);
        step("h0", 0, 0, 8'h01, 1);
        step("h1", 0, 0, 8'hFE, 0);
        step("h2", 0, 0, 8'h01, 1);
        chk("hold_lit", 32'(bus.B), 32'hFF8F);

        wide = 9'h0FF;
        step("trunc", 0, 1, wide[7:0], 0);
        chk("trunc_lit", 32'(bus.B), 32'hFFFF);

        for (int i = 0; i < 300; i++) begin
            ra = 8'($urandom_range(0, 255));
            step("rnd", ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                 ra, 1'($urandom_range(0, 1)));
        end

        step("rst_mid", 1, 1, 8'h80, 0);
        step("post_rst", 0, 1, 8'h81, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
